// File: rtl/valu_add_arbiter_pkg.sv
// Shared defaults and the in-flight tag type for the two-requester VALU add arbiter.
package valu_add_arbiter_pkg;

    localparam int unsigned DEF_DATA_WIDTH      = 64;
    localparam int unsigned DEF_SEW_WIDTH       = 2;
    localparam int unsigned DEF_OPSEL_WIDTH     = 9;
    localparam int unsigned DEF_PIPE_LATENCY    = 6;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/valu_add_arbiter_if.sv
// Requester, response and ALU-side signals of the VALU add arbiter.
interface valu_add_arbiter_if
    import valu_add_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_WIDTH,
    parameter int unsigned SEW_W   = DEF_SEW_WIDTH,
    parameter int unsigned OPSEL_W = DEF_OPSEL_WIDTH
);
    logic               req0_valid;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_vec0;
    logic [DATA_W-1:0]  req0_vec1;
    logic [SEW_W-1:0]   req0_sew;
    logic [OPSEL_W-1:0] req0_opSel;
    logic               resp0_valid;
    logic [DATA_W-1:0]  resp0_data;

    logic               req1_valid;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_vec0;
    logic [DATA_W-1:0]  req1_vec1;
    logic [SEW_W-1:0]   req1_sew;
    logic [OPSEL_W-1:0] req1_opSel;
    logic               resp1_valid;
    logic [DATA_W-1:0]  resp1_data;

    logic               alu_valid;
    logic [DATA_W-1:0]  alu_vec0;
    logic [DATA_W-1:0]  alu_vec1;
    logic [SEW_W-1:0]   alu_sew;
    logic [OPSEL_W-1:0] alu_opSel;
    logic               alu_out_valid;
    logic [DATA_W-1:0]  alu_out_vec;
    logic               err_mismatch;

    modport slave (
        input  req0_valid, req0_vec0, req0_vec1, req0_sew, req0_opSel,
        input  req1_valid, req1_vec0, req1_vec1, req1_sew, req1_opSel,
        input  alu_out_valid, alu_out_vec,
        output req0_ready, resp0_valid, resp0_data,
        output req1_ready, resp1_valid, resp1_data,
        output alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opSel, err_mismatch
    );

    modport master (
        output req0_valid, req0_vec0, req0_vec1, req0_sew, req0_opSel,
        output req1_valid, req1_vec0, req1_vec1, req1_sew, req1_opSel,
        output alu_out_valid, alu_out_vec,
        input  req0_ready, resp0_valid, resp0_data,
        input  req1_ready, resp1_valid, resp1_data,
        input  alu_valid, alu_vec0, alu_vec1, alu_sew, alu_opSel, err_mismatch
    );

endinterface

// File: rtl/valu_tag_pipe.sv
// Fixed-depth shift register carrying {valid, id} alongside the ALU pipeline.
module valu_tag_pipe
    import valu_add_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_PIPE_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t head
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign head = stage[DEPTH-1];

endmodule

// File: rtl/valu_add_arbiter.sv
// Round-robin arbiter sharing one pipelined VALU between two requesters with
// per-requester credit limits and tag-based response routing.
module valu_add_arbiter
    import valu_add_arbiter_pkg::*;
#(
    parameter int unsigned REQ_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned SEW_WIDTH       = DEF_SEW_WIDTH,
    parameter int unsigned OPSEL_WIDTH     = DEF_OPSEL_WIDTH,
    parameter int unsigned PIPE_LATENCY    = DEF_PIPE_LATENCY,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic              clk,
    input  logic              rst,
    valu_add_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             last_grant;
    logic             alu_id;
    logic             elig0, elig1;
    logic             grant0, grant1;
    logic             acc0, acc1;
    logic             resp0, resp1;
    tag_t             tag_in;
    tag_t             head;

    // Eligibility and round-robin grant; nothing is granted while in reset.
    always_comb begin
        elig0  = !rst && bus.req0_valid && (cnt0 < CNT_MAX);
        elig1  = !rst && bus.req1_valid && (cnt1 < CNT_MAX);
        grant0 = elig0 && (!elig1 || last_grant);
        grant1 = elig1 && (!elig0 || !last_grant);
        acc0   = bus.req0_valid && grant0;
        acc1   = bus.req1_valid && grant1;
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
    end

    // Issue registers: the accepted payload, or all-zero when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_valid <= 1'b0;
            bus.alu_vec0  <= '0;
            bus.alu_vec1  <= '0;
            bus.alu_sew   <= '0;
            bus.alu_opSel <= '0;
            alu_id        <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            bus.alu_valid <= acc0 || acc1;
            alu_id        <= acc1;
            if (acc0) begin
                bus.alu_vec0  <= bus.req0_vec0;
                bus.alu_vec1  <= bus.req0_vec1;
                bus.alu_sew   <= bus.req0_sew;
                bus.alu_opSel <= bus.req0_opSel;
            end else if (acc1) begin
                bus.alu_vec0  <= bus.req1_vec0;
                bus.alu_vec1  <= bus.req1_vec1;
                bus.alu_sew   <= bus.req1_sew;
                bus.alu_opSel <= bus.req1_opSel;
            end else begin
                bus.alu_vec0  <= '0;
                bus.alu_vec1  <= '0;
                bus.alu_sew   <= '0;
                bus.alu_opSel <= '0;
            end
            if (acc0 || acc1) last_grant <= acc1;
        end
    end

    assign tag_in = '{valid: bus.alu_valid, id: alu_id};

    valu_tag_pipe #(
        .DEPTH (PIPE_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (tag_in),
        .head   (head)
    );

    // Result routing by the tag that travelled with the operation.
    always_comb begin
        resp0 = !rst && bus.alu_out_valid && head.valid && !head.id;
        resp1 = !rst && bus.alu_out_valid && head.valid && head.id;
        bus.resp0_valid = resp0;
        bus.resp1_valid = resp1;
        bus.resp0_data  = resp0 ? bus.alu_out_vec : '0;
        bus.resp1_data  = resp1 ? bus.alu_out_vec : '0;
    end

    // Credit counters: a same-cycle accept and retire cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (acc0 && !resp0)      cnt0 <= cnt0 + CNT_W'(1);
            else if (!acc0 && resp0) cnt0 <= cnt0 - CNT_W'(1);
            if (acc1 && !resp1)      cnt1 <= cnt1 + CNT_W'(1);
            else if (!acc1 && resp1) cnt1 <= cnt1 - CNT_W'(1);
        end
    end

    // Sticky flag for an ALU result that does not line up with the tag head.
    always_ff @(posedge clk) begin
        if (rst)                                   bus.err_mismatch <= 1'b0;
        else if (bus.alu_out_valid != head.valid)  bus.err_mismatch <= 1'b1;
    end

endmodule

// File: tb/tb_valu_add_arbiter.sv
// Bench for valu_add_arbiter: ALU delay-line model plus a transaction-level scoreboard.
module tb_valu_add_arbiter;
    import valu_add_arbiter_pkg::*;

    localparam int unsigned DW   = 64;
    localparam int unsigned SW   = 2;
    localparam int unsigned OW   = 9;
    localparam int unsigned LAT  = 6;
    localparam int unsigned MAXO = 4;

    logic clk = 1'b0;
    logic rst;
    logic inject;
    always #5 clk = ~clk;

    valu_add_arbiter_if #(.DATA_W(DW), .SEW_W(SW), .OPSEL_W(OW)) bus ();

    valu_add_arbiter #(
        .REQ_DATA_WIDTH (DW), .SEW_WIDTH (SW), .OPSEL_WIDTH (OW),
        .PIPE_LATENCY (LAT), .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
        if (op == '0)  return a + b;
        else if (op[0]) return a - b;
        else            return a ^ b;
    endfunction

    // External ALU: fixed LAT-cycle delay line sharing the arbiter's reset.
    typedef struct packed { logic v; logic [DW-1:0] d; } alu_slot_t;
    alu_slot_t alu_pipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LAT); i++) alu_pipe[i] <= '0;
        end else begin
            alu_pipe[0] <= '{v: bus.alu_valid,
                             d: bus.alu_valid ? alu_fn(bus.alu_vec0, bus.alu_vec1, bus.alu_opSel) : '0};
            for (int i = 1; i < int'(LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
        end
    end
    assign bus.alu_out_valid = alu_pipe[LAT-1].v | inject;
    assign bus.alu_out_vec   = alu_pipe[LAT-1].d;

    // Scoreboard: expected responses in issue order with their due cycle.
    typedef struct { int due; bit id; logic [DW-1:0] data; } exp_t;
    exp_t q[$];
    int   cnt [2];
    bit   last;
    bit   err_exp;
    logic ev;
    logic [DW-1:0] ea, eb;
    logic [SW-1:0] es;
    logic [OW-1:0] eo;

    int cyc, n_tests, n_fail;
    int n_resp0, n_resp1, n_alu, n_acc, last_r0_cyc;
    logic [DW-1:0] last_r0_data;
    bit s_rdy0, s_rdy1, s_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input bit x, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [SW-1:0] s, input logic [OW-1:0] o);
        if (!x) begin
            bus.req0_valid = v; bus.req0_vec0 = a; bus.req0_vec1 = b; bus.req0_sew = s; bus.req0_opSel = o;
        end else begin
            bus.req1_valid = v; bus.req1_vec0 = a; bus.req1_vec1 = b; bus.req1_sew = s; bus.req1_opSel = o;
        end
    endtask

    // One cycle: compare every output against the scoreboard, then advance it.
    task automatic tick();
        bit e0, e1, g0, g1, hit, r0, r1;
        logic [DW-1:0] rd;
        #1;
        hit = (q.size() > 0) && (q[0].due == cyc);
        e0  = !rst && bus.req0_valid && (cnt[0] < int'(MAXO));
        e1  = !rst && bus.req1_valid && (cnt[1] < int'(MAXO));
        g0  = e0 && (!e1 || last);
        g1  = e1 && (!e0 || !last);
        r0 = 1'b0; r1 = 1'b0; rd = '0;
        if (hit && !rst) begin r0 = !q[0].id; r1 = q[0].id; rd = q[0].data; end

        chk("req0_ready",  64'(bus.req0_ready),  64'(g0));
        chk("req1_ready",  64'(bus.req1_ready),  64'(g1));
        chk("resp0_valid", 64'(bus.resp0_valid), 64'(r0));
        chk("resp1_valid", 64'(bus.resp1_valid), 64'(r1));
        chk("resp0_data",  bus.resp0_data, r0 ? rd : '0);
        chk("resp1_data",  bus.resp1_data, r1 ? rd : '0);
        chk("alu_valid",   64'(bus.alu_valid), 64'(ev));
        chk("alu_vec0",    bus.alu_vec0, ea);
        chk("alu_vec1",    bus.alu_vec1, eb);
        chk("alu_sew",     64'(bus.alu_sew), 64'(es));
        chk("alu_opSel",   64'(bus.alu_opSel), 64'(eo));
        chk("err_mismatch", 64'(bus.err_mismatch), 64'(err_exp));

        s_rdy0 = bus.req0_ready; s_rdy1 = bus.req1_ready; s_err = bus.err_mismatch;
        if (bus.resp0_valid) begin n_resp0++; last_r0_cyc = cyc; last_r0_data = bus.resp0_data; end
        if (bus.resp1_valid) n_resp1++;
        if (bus.alu_valid) n_alu++;
        if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) n_acc++;

        if (rst) begin
            q.delete(); cnt[0] = 0; cnt[1] = 0; last = 1'b1; err_exp = 1'b0;
            ev = 1'b0; ea = '0; eb = '0; es = '0; eo = '0;
        end else begin
            if (inject && !hit) err_exp = 1'b1;
            if (hit) begin cnt[q[0].id]--; void'(q.pop_front()); end
            ev = g0 || g1;
            if (g0) begin
                ea = bus.req0_vec0; eb = bus.req0_vec1; es = bus.req0_sew; eo = bus.req0_opSel;
            end else if (g1) begin
                ea = bus.req1_vec0; eb = bus.req1_vec1; es = bus.req1_sew; eo = bus.req1_opSel;
            end else begin
                ea = '0; eb = '0; es = '0; eo = '0;
            end
            if (g0 || g1) begin
                last = g1;
                cnt[g1]++;
                q.push_back('{due: cyc + int'(LAT) + 1, id: g1, data: alu_fn(ea, eb, eo)});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_resp0 = 0; n_resp1 = 0; n_alu = 0; n_acc = 0;
    endtask

    bit rdy0_log [20];
    bit rdy1_log [20];
    int acc_cyc;

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        inject = 1'b0; rst = 1'b1;
        idle();
        last = 1'b1; err_exp = 1'b0; cnt[0] = 0; cnt[1] = 0;
        ev = 1'b0; ea = '0; eb = '0; es = '0; eo = '0;
        @(posedge clk);
        #1;
        // Reset state is covered by the scoreboard during this reset cycle.
        do_reset();

        // Single add from requester 0.
        set_req(1'b0, 1'b1, 64'd5, 64'd3, 2'd3, '0);
        acc_cyc = cyc;
        tick();
        idle();
        repeat (10) tick();
        chk("single_resp0_count", 64'(n_resp0), 64'd1);
        chk("single_resp1_count", 64'(n_resp1), 64'd0);
        chk("single_latency", 64'(last_r0_cyc - acc_cyc), 64'(LAT + 1));
        chk("single_data", last_r0_data, 64'd8);

        // Continuous contention for 8 cycles after reset.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_req(1'b0, 1'b1, 64'(i), 64'(100 + i), 2'(i), 9'(i));
            set_req(1'b1, 1'b1, 64'(200 + i), 64'(i), 2'(i + 1), 9'(i + 1));
            tick();
            chk("contend_grant0", 64'(s_rdy0), 64'((i % 2) == 0));
        end
        idle();
        repeat (10) tick();
        chk("contend_alu_pulses", 64'(n_alu), 64'd8);
        chk("contend_resp_total", 64'(n_resp0 + n_resp1), 64'd8);

        // Credit limit on requester 0 while requester 1 keeps issuing.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_req(1'b0, 1'b1, 64'($urandom), 64'($urandom), 2'(i), 9'(2 * i));
            set_req(1'b1, i >= 4, 64'($urandom), 64'($urandom), 2'(i), 9'(i));
            tick();
            rdy0_log[i] = s_rdy0;
            rdy1_log[i] = s_rdy1;
        end
        idle();
        repeat (12) tick();
        for (int i = 0; i < 4; i++) chk("limit_early_ready0", 64'(rdy0_log[i]), 64'd1);
        for (int i = 4; i < 8; i++) chk("limit_blocked_ready0", 64'(rdy0_log[i]), 64'd0);
        chk("limit_other_ready1", 64'(rdy1_log[4]), 64'd1);
        chk("limit_reopen_ready0", 64'(rdy0_log[8]), 64'd1);

        // Spurious ALU result with nothing in flight.
        do_reset();
        repeat (3) tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (4) begin
            tick();
            chk("spurious_err_sticky", 64'(s_err), 64'd1);
        end
        do_reset();
        tick();
        chk("spurious_err_cleared", 64'(s_err), 64'd0);

        // Reset with three transactions in flight.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 1'b1, 64'(i + 7), 64'(i), '0, '0);
            set_req(1'b1, 1'b1, 64'(i), 64'(i + 9), '0, '0);
            tick();
        end
        do_reset();
        repeat (12) tick();
        chk("flush_resp0_count", 64'(n_resp0), 64'd0);
        chk("flush_resp1_count", 64'(n_resp1), 64'd0);
        chk("flush_alu_pulses", 64'(n_alu), 64'd0);

        // Random traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            set_req(1'b0, $urandom_range(0, 99) < 70, {$urandom, $urandom}, {$urandom, $urandom},
                    2'($urandom), 9'($urandom_range(0, 3)));
            set_req(1'b1, $urandom_range(0, 99) < 60, {$urandom, $urandom}, {$urandom, $urandom},
                    2'($urandom), 9'($urandom_range(0, 3)));
            tick();
        end
        idle();
        repeat (12) tick();
        chk("random_err_clear", 64'(s_err), 64'd0);
        chk("random_all_retired", 64'(n_resp0 + n_resp1), 64'(n_acc));
        chk("random_queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
